// File: rtl/config_eeprom_pkg.sv
// Shared types and constants for the config_eeprom shadow NVM image.
package config_eeprom_pkg;

    // Controller states: init fill sequence, then idle with read-modify-write commits.
    typedef enum logic [2:0] {
        ST_INIT_WAIT,
        ST_INIT_MAC,
        ST_INIT_FILL,
        ST_INIT_CSUM,
        ST_IDLE,
        ST_WR_OLD,
        ST_WR_COMMIT
    } state_e;

    // Word addresses of the fixed default-image entries.
    localparam int unsigned ADDR_MAC0    = 32'h00;
    localparam int unsigned ADDR_MAC1    = 32'h01;
    localparam int unsigned ADDR_MAC2    = 32'h02;
    localparam int unsigned ADDR_ICW1    = 32'h0A;
    localparam int unsigned ADDR_SUB_PID = 32'h0B;
    localparam int unsigned ADDR_SUB_VID = 32'h0C;
    localparam int unsigned ADDR_PID     = 32'h0D;
    localparam int unsigned ADDR_VID     = 32'h0E;
    localparam int unsigned ADDR_ICW2    = 32'h0F;
    localparam int unsigned ADDR_BAMSO   = 32'h30;

    // Fold the 57-bit DNA ID into the 24-bit device-unique MAC suffix.
    function automatic logic [23:0] mac_fold(input logic [56:0] id);
        return 24'(id[56:48]) + id[47:24] + id[23:0];
    endfunction

endpackage

// File: rtl/config_eeprom_if.sv
// Read/write/MAC signal bundle between the EEPROM shadow and its users.
interface config_eeprom_if;
    logic [56:0] id;
    logic        id_valid;
    logic [7:0]  read_addr;
    logic        read_enable;
    logic [15:0] read_data;
    logic        read_valid;
    logic        wr_req;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic        wr_err;
    logic        ready;
    logic [47:0] mac_address;
    logic        mac_valid;

    modport master (
        output id, id_valid, read_addr, read_enable, wr_req, wr_addr, wr_data,
        input  read_data, read_valid, wr_ack, wr_err, ready, mac_address, mac_valid
    );

    modport slave (
        input  id, id_valid, read_addr, read_enable, wr_req, wr_addr, wr_data,
        output read_data, read_valid, wr_ack, wr_err, ready, mac_address, mac_valid
    );
endinterface

// File: rtl/config_eeprom_defaults.sv
// Combinational default NVM image word for a given address and MAC suffix.
module config_eeprom_defaults
    import config_eeprom_pkg::*;
#(
    parameter int unsigned ADDR_W  = 6,
    parameter logic [23:0] MAC_OUI = 24'hEC3F05,
    parameter logic [15:0] ICW1    = 16'h6000,
    parameter logic [15:0] SUB_PID = 16'h6120,
    parameter logic [15:0] SUB_VID = 16'hFACE,
    parameter logic [15:0] PID     = 16'h0050,
    parameter logic [15:0] VID     = 16'h8086,
    parameter logic [15:0] ICW2    = 16'h1000,
    parameter logic [15:0] BAMSO   = 16'h8000
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [23:0]       mac24,
    output logic [15:0]       word_c
);

    // Address decode of the default image; unlisted words are zero.
    always_comb begin
        word_c = '0;
        case (addr)
            ADDR_W'(ADDR_MAC0):    word_c = {MAC_OUI[15:8], MAC_OUI[23:16]};
            ADDR_W'(ADDR_MAC1):    word_c = {mac24[23:16], MAC_OUI[7:0]};
            ADDR_W'(ADDR_MAC2):    word_c = {mac24[7:0], mac24[15:8]};
            ADDR_W'(ADDR_ICW1):    word_c = ICW1;
            ADDR_W'(ADDR_SUB_PID): word_c = SUB_PID;
            ADDR_W'(ADDR_SUB_VID): word_c = SUB_VID;
            ADDR_W'(ADDR_PID):     word_c = PID;
            ADDR_W'(ADDR_VID):     word_c = VID;
            ADDR_W'(ADDR_ICW2):    word_c = ICW2;
            ADDR_W'(ADDR_BAMSO):   word_c = BAMSO;
            default:               word_c = '0;
        endcase
    end

endmodule

// File: rtl/config_eeprom.sv
// Writable shadow EEPROM with auto-maintained checksum word at DEPTH-1.
// Optional: define CONFIG_EEPROM_MAC_LOCK_EN to make words 0..2 read-only.
module config_eeprom
    import config_eeprom_pkg::*;
#(
    parameter int unsigned ADDR_W      = 6,
    parameter logic [23:0] MAC_OUI     = 24'hEC3F05,
    parameter logic [15:0] ICW1        = 16'h6000,
    parameter logic [15:0] SUB_PID     = 16'h6120,
    parameter logic [15:0] SUB_VID     = 16'hFACE,
    parameter logic [15:0] PID         = 16'h0050,
    parameter logic [15:0] VID         = 16'h8086,
    parameter logic [15:0] ICW2        = 16'h1000,
    parameter logic [15:0] BAMSO       = 16'h8000,
    parameter logic [15:0] CSUM_TARGET = 16'hBABA
) (
    input logic            clk_i,
    input logic            rst_i,
    config_eeprom_if.slave bus
);

    localparam int unsigned       DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] CSUM_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_FILL = ADDR_W'(DEPTH - 2);

    logic [15:0] mem [DEPTH];

    state_e            state_q, state_d;
    logic [23:0]       mac24_q, mac24_d;
    logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
    logic [15:0]       sum_q, sum_d;
    logic [15:0]       csum_q, csum_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              wr_drop_q, wr_drop_d;
    logic [15:0]       old_q, old_d;
    logic [15:0]       read_data_q, read_data_d;
    logic              read_valid_q, read_valid_d;
    logic              wr_ack_q, wr_ack_d;
    logic              wr_err_q, wr_err_d;
    logic              ready_q, ready_d;
    logic              mac_valid_q, mac_valid_d;

    logic              we_a, we_b;
    logic [ADDR_W-1:0] waddr_a;
    logic [15:0]       wdata_a, wdata_b;
    logic [15:0]       def_word_c;
    logic [15:0]       rd_word_c;
    logic [15:0]       csum_new_c;
    logic              wr_drop_c;

    config_eeprom_defaults #(
        .ADDR_W (ADDR_W),
        .MAC_OUI(MAC_OUI),
        .ICW1   (ICW1),
        .SUB_PID(SUB_PID),
        .SUB_VID(SUB_VID),
        .PID    (PID),
        .VID    (VID),
        .ICW2   (ICW2),
        .BAMSO  (BAMSO)
    ) u_defaults (
        .addr  (fill_addr_q),
        .mac24 (mac24_q),
        .word_c(def_word_c)
    );

    assign csum_new_c = csum_q + old_q - wr_data_q;

    // Out-of-range reads return all-ones like an unprogrammed EEPROM.
    assign rd_word_c = ({1'b0, bus.read_addr} < 9'(DEPTH))
                       ? mem[bus.read_addr[ADDR_W-1:0]] : 16'hFFFF;

    // Writes the block refuses: checksum word, out of range, optionally MAC words.
    always_comb begin
        wr_drop_c = ({1'b0, bus.wr_addr} >= 9'(DEPTH - 1));
`ifdef CONFIG_EEPROM_MAC_LOCK_EN
        if (bus.wr_addr <= 8'(ADDR_MAC2)) begin
            wr_drop_c = 1'b1;
        end
`endif
    end

    // Next-state, datapath and RAM write-port control.
    always_comb begin
        state_d      = state_q;
        mac24_d      = mac24_q;
        fill_addr_d  = fill_addr_q;
        sum_d        = sum_q;
        csum_d       = csum_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_drop_d    = wr_drop_q;
        old_d        = old_q;
        read_data_d  = read_data_q;
        read_valid_d = 1'b0;
        wr_ack_d     = 1'b0;
        wr_err_d     = 1'b0;
        mac_valid_d  = mac_valid_q;
        we_a         = 1'b0;
        waddr_a      = '0;
        wdata_a      = '0;
        we_b         = 1'b0;
        wdata_b      = '0;

        case (state_q)
            ST_INIT_WAIT: begin
                if (bus.id_valid) begin
                    state_d = ST_INIT_MAC;
                end
            end
            ST_INIT_MAC: begin
                mac24_d     = mac_fold(bus.id);
                fill_addr_d = '0;
                sum_d       = '0;
                state_d     = ST_INIT_FILL;
            end
            ST_INIT_FILL: begin
                we_a        = 1'b1;
                waddr_a     = fill_addr_q;
                wdata_a     = def_word_c;
                sum_d       = sum_q + def_word_c;
                fill_addr_d = fill_addr_q + ADDR_W'(1);
                if (fill_addr_q == LAST_FILL) begin
                    state_d = ST_INIT_CSUM;
                end
            end
            ST_INIT_CSUM: begin
                we_b        = 1'b1;
                wdata_b     = CSUM_TARGET - sum_q;
                csum_d      = CSUM_TARGET - sum_q;
                mac_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_IDLE: begin
                if (bus.read_enable) begin
                    read_data_d  = rd_word_c;
                    read_valid_d = 1'b1;
                end else if (bus.wr_req) begin
                    wr_addr_d = bus.wr_addr[ADDR_W-1:0];
                    wr_data_d = bus.wr_data;
                    wr_drop_d = wr_drop_c;
                    state_d   = ST_WR_OLD;
                end
            end
            ST_WR_OLD: begin
                old_d    = mem[wr_addr_q];
                wr_ack_d = 1'b1;
                wr_err_d = wr_drop_q;
                state_d  = ST_WR_COMMIT;
            end
            ST_WR_COMMIT: begin
                if (!wr_drop_q) begin
                    we_a    = 1'b1;
                    waddr_a = wr_addr_q;
                    wdata_a = wr_data_q;
                    we_b    = 1'b1;
                    wdata_b = csum_new_c;
                    csum_d  = csum_new_c;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_INIT_WAIT;
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_INIT_WAIT;
            mac24_q      <= '0;
            fill_addr_q  <= '0;
            sum_q        <= '0;
            csum_q       <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_drop_q    <= 1'b0;
            old_q        <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            wr_ack_q     <= 1'b0;
            wr_err_q     <= 1'b0;
            ready_q      <= 1'b0;
            mac_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mac24_q      <= mac24_d;
            fill_addr_q  <= fill_addr_d;
            sum_q        <= sum_d;
            csum_q       <= csum_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_drop_q    <= wr_drop_d;
            old_q        <= old_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            wr_ack_q     <= wr_ack_d;
            wr_err_q     <= wr_err_d;
            ready_q      <= ready_d;
            mac_valid_q  <= mac_valid_d;
        end
    end

    // Image RAM; port b is dedicated to the checksum word. Reset cancels writes.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (we_a) begin
                mem[waddr_a] <= wdata_a;
            end
            if (we_b) begin
                mem[CSUM_ADDR] <= wdata_b;
            end
        end
    end

    assign bus.read_data   = read_data_q;
    assign bus.read_valid  = read_valid_q;
    assign bus.wr_ack      = wr_ack_q;
    assign bus.wr_err      = wr_err_q;
    assign bus.ready       = ready_q;
    assign bus.mac_address = {MAC_OUI, mac24_q};
    assign bus.mac_valid   = mac_valid_q;

endmodule

// File: tb/tb_config_eeprom.sv
// Directed self-checking bench for config_eeprom (DEPTH = 64).
module tb_config_eeprom;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    config_eeprom_if bus ();

    config_eeprom u_dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 20; k++) begin
            if (bus.ready === 1'b1) return;
            tick();
        end
        check("ready_timeout", 64'(bus.ready), 64'(1));
    endtask

    task automatic wait_mac(output int n);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            n++;
            if (bus.mac_valid === 1'b1) return;
        end
    endtask

    task automatic do_read(input logic [7:0] addr, output logic [15:0] data);
        wait_ready();
        bus.read_addr   = addr;
        bus.read_enable = 1'b1;
        tick();
        bus.read_enable = 1'b0;
        check("rvalid", 64'(bus.read_valid), 64'(1));
        data = bus.read_data;
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [15:0] data,
                            output logic err, output int lat);
        wait_ready();
        bus.wr_addr = addr;
        bus.wr_data = data;
        bus.wr_req  = 1'b1;
        lat = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            lat++;
            if (bus.wr_ack === 1'b1) break;
        end
        err = bus.wr_err;
        bus.wr_req = 1'b0;
        tick();
    endtask

    task automatic sum_all(output logic [15:0] s);
        logic [15:0] d;
        s = '0;
        for (int i = 0; i < 64; i++) begin
            do_read(8'(i), d);
            s = s + d;
        end
    endtask

    initial begin
        logic [15:0] d;
        logic [15:0] s;
        logic        e;
        int          lat;
        int          n;
        int          acks;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.id          = '0;
        bus.id_valid    = 1'b0;
        bus.read_addr   = '0;
        bus.read_enable = 1'b0;
        bus.wr_req      = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        repeat (3) tick();

        // Reset values
        check("rst_ready", 64'(bus.ready), 64'(0));
        check("rst_mac_valid", 64'(bus.mac_valid), 64'(0));
        check("rst_read_valid", 64'(bus.read_valid), 64'(0));
        check("rst_read_data", 64'(bus.read_data), 64'(0));
        check("rst_wr_ack", 64'(bus.wr_ack), 64'(0));
        check("rst_wr_err", 64'(bus.wr_err), 64'(0));
        check("rst_mac_addr", 64'(bus.mac_address), 64'(48'hEC3F05000000));

        // Stays in INIT_WAIT without id_valid
        rst = 1'b0;
        repeat (4) tick();
        check("wait_no_id", 64'(bus.mac_valid), 64'(0));

        // Init fill: mac_valid exactly DEPTH+2 cycles after id_valid
        bus.id       = {9'h0, 24'h0, 24'h123456};
        bus.id_valid = 1'b1;
        wait_mac(n);
        check("init_latency", 64'(n), 64'(66));
        check("init_mac_addr", 64'(bus.mac_address), 64'(48'hEC3F05123456));
        check("init_ready", 64'(bus.ready), 64'(1));

        do_read(8'h00, d); check("w00", 64'(d), 64'(16'h3FEC));
        do_read(8'h01, d); check("w01", 64'(d), 64'(16'h1205));
        do_read(8'h02, d); check("w02", 64'(d), 64'(16'h5634));
        do_read(8'h0E, d); check("w0e", 64'(d), 64'(16'h8086));
        do_read(8'h30, d); check("w30", 64'(d), 64'(16'h8000));
        do_read(8'h03, d); check("w03", 64'(d), 64'(16'h0000));
        do_read(8'h3F, d); check("w3f_init", 64'(d), 64'(16'h45D1));
        do_read(8'h40, d); check("oor_read", 64'(d), 64'(16'hFFFF));
        sum_all(s);        check("sum_init", 64'(s), 64'(16'hBABA));

        // Normal write with checksum maintenance
        do_write(8'h03, 16'h1111, e, lat);
        check("wr03_lat", 64'(lat), 64'(2));
        check("wr03_err", 64'(e), 64'(0));
        do_read(8'h03, d); check("w03_new", 64'(d), 64'(16'h1111));
        do_read(8'h3F, d); check("w3f_wr", 64'(d), 64'(16'h34C0));
        sum_all(s);        check("sum_wr", 64'(s), 64'(16'hBABA));

        // Dropped writes: checksum word and out of range
        do_write(8'h3F, 16'h0000, e, lat);
        check("drop3f_lat", 64'(lat), 64'(2));
        check("drop3f_err", 64'(e), 64'(1));
        do_read(8'h3F, d); check("w3f_keep", 64'(d), 64'(16'h34C0));
        do_write(8'h50, 16'h1234, e, lat);
        check("drop50_lat", 64'(lat), 64'(2));
        check("drop50_err", 64'(e), 64'(1));
        do_read(8'h10, d); check("w10_keep", 64'(d), 64'(16'h0000));

        // MAC word write: locked or writable depending on build
        do_write(8'h01, 16'hFFFF, e, lat);
`ifdef CONFIG_EEPROM_MAC_LOCK_EN
        check("mac_wr_err", 64'(e), 64'(1));
        do_read(8'h01, d); check("w01_lock", 64'(d), 64'(16'h1205));
        do_read(8'h3F, d); check("w3f_lock", 64'(d), 64'(16'h34C0));
`else
        check("mac_wr_err", 64'(e), 64'(0));
        do_read(8'h01, d); check("w01_open", 64'(d), 64'(16'hFFFF));
        do_read(8'h3F, d); check("w3f_open", 64'(d), 64'(16'h46C6));
`endif
        check("mac_addr_keep", 64'(bus.mac_address), 64'(48'hEC3F05123456));
        sum_all(s); check("sum_mac", 64'(s), 64'(16'hBABA));

        // Read/write collision: read first, write accepted the following cycle
        wait_ready();
        bus.read_addr   = 8'h0E;
        bus.read_enable = 1'b1;
        bus.wr_addr     = 8'h04;
        bus.wr_data     = 16'h2222;
        bus.wr_req      = 1'b1;
        tick();
        bus.read_enable = 1'b0;
        check("coll_rvalid", 64'(bus.read_valid), 64'(1));
        check("coll_rdata", 64'(bus.read_data), 64'(16'h8086));
        check("coll_no_ack", 64'(bus.wr_ack), 64'(0));
        lat = 1;
        for (int k = 0; k < 8; k++) begin
            tick();
            lat++;
            if (bus.wr_ack === 1'b1) break;
        end
        bus.wr_req = 1'b0;
        check("coll_wr_lat", 64'(lat), 64'(3));
        tick();
        do_read(8'h04, d); check("w04_coll", 64'(d), 64'(16'h2222));

        // id_valid dropping after init has no effect
        bus.id_valid = 1'b0;
        repeat (3) tick();
        check("idv_low_mac", 64'(bus.mac_valid), 64'(1));
        check("idv_low_ready", 64'(bus.ready), 64'(1));
        bus.id_valid = 1'b1;

        // Reset during WR_OLD, then rebuild with a new id
        wait_ready();
        bus.wr_addr = 8'h03;
        bus.wr_data = 16'h5555;
        bus.wr_req  = 1'b1;
        tick();
        rst    = 1'b1;
        bus.id = {9'h1FF, 24'h000100, 24'hFFFF00};
        tick();
        check("rst_mid_ack", 64'(bus.wr_ack), 64'(0));
        check("rst_mid_ready", 64'(bus.ready), 64'(0));
        check("rst_mid_macv", 64'(bus.mac_valid), 64'(0));
        bus.wr_req = 1'b0;
        rst = 1'b0;
        acks = 0;
        tick();
        if (bus.wr_ack === 1'b1) acks++;
        tick();
        if (bus.wr_ack === 1'b1) acks++;
        check("rst_no_late_ack", 64'(acks), 64'(0));

        // Now in INIT_FILL: reads are ignored
        bus.read_addr   = 8'h00;
        bus.read_enable = 1'b1;
        tick();
        bus.read_enable = 1'b0;
        check("fill_no_rvalid", 64'(bus.read_valid), 64'(0));
        check("fill_not_ready", 64'(bus.ready), 64'(0));

        wait_mac(n);
        check("refill_macv", 64'(bus.mac_valid), 64'(1));
        check("refill_mac_addr", 64'(bus.mac_address), 64'(48'hEC3F050001FF));
        do_read(8'h03, d); check("refill_w03", 64'(d), 64'(16'h0000));
        do_read(8'h02, d); check("refill_w02", 64'(d), 64'(16'hFF01));
        do_read(8'h3F, d); check("refill_w3f", 64'(d), 64'(16'hAF04));
        sum_all(s);        check("refill_sum", 64'(s), 64'(16'hBABA));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/config_eeprom.md
Name: config_eeprom

Overview:
Parametrised successor to the fixed NVM-image ROM. It is a writable shadow EEPROM: a DEPTH-word × 16-bit RAM, filled after reset with the default NIC image and a device-unique MAC derived from the DNA ID. Sits between the DNA reader and the e1000 EERD/EECD access logic. It maintains the checksum word automatically, on both the init fill and every runtime write, so that the words always sum to CSUM_TARGET.

Parameters:
ADDR_W, 6, word address width; DEPTH = 2**ADDR_W; must be >= 6 (fixed words up to 0x30); checksum word at DEPTH-1
MAC_OUI, 24'hEC3F05, upper 24 bits of MAC
ICW1, 16'h6000, default word 0x0A
SUB_PID, 16'h6120, default word 0x0B
SUB_VID, 16'hFACE, default word 0x0C
PID, 16'h0050, default word 0x0D
VID, 16'h8086, default word 0x0E
ICW2, 16'h1000, default word 0x0F
BAMSO, 16'h8000, default word 0x30
CSUM_TARGET, 16'hBABA, required mod-2^16 sum of all DEPTH words

Ports:
clk_i  in  1  clock; single clock domain
rst_i  in  1  synchronous, active-high reset
id  in  57  DNA device ID
id_valid  in  1  id stable; level
read_addr  in  8  word address
read_enable  in  1  read request; accepted only when ready=1
read_data  out  16  registered read word
read_valid  out  1  one-cycle pulse, read_data valid
wr_req  in  1  write request; hold until wr_ack
wr_addr  in  8  write word address
wr_data  in  16  write word
wr_ack  out  1  one-cycle pulse, write completed or dropped
wr_err  out  1  one-cycle pulse with wr_ack when the write was dropped
ready  out  1  1 in IDLE only
mac_address  out  48  {MAC_OUI, mac24}
mac_valid  out  1  1 once init fill is complete

Behaviour:
- Reset: FSM=INIT_WAIT. Outputs read_data=0, read_valid=0, wr_ack=0, wr_err=0, ready=0, mac_valid=0, mac_address={MAC_OUI,24'h0}. RAM content is don't-care until refilled.
- States: INIT_WAIT → INIT_MAC → INIT_FILL → INIT_CSUM → IDLE ↔ WR_OLD → WR_COMMIT → IDLE.
- INIT_WAIT: wait for id_valid=1, then go to INIT_MAC.
- INIT_MAC: compute mac24 = (id[56:48] + id[47:24] + id[23:0]) mod 2^24, zero-extended. Register mac24. Clear fill addr and sum.
- INIT_FILL: one word per cycle, addr 0..DEPTH-2. Write the default word and accumulate sum += word (mod 2^16).
- Default image:
  - w0 = {OUI[15:8], OUI[23:16]}
  - w1 = {mac24[23:16], OUI[7:0]}
  - w2 = {mac24[7:0], mac24[15:8]}
  - 0x0A..0x0F = ICW1, SUB_PID, SUB_VID, PID, VID, ICW2
  - 0x30 = BAMSO
  - all other words = 0
- INIT_CSUM: write word DEPTH-1 = CSUM_TARGET - sum; hold running csum register = that value. Next cycle IDLE, mac_valid=1.
- Init latency from id_valid: DEPTH+2 cycles.
- Read: accepted in IDLE when read_enable=1. read_data and read_valid are presented the next cycle (latency 1).
- Read address >= DEPTH returns 16'hFFFF. Reads outside IDLE are ignored (no read_valid).
- Write: accepted in IDLE when wr_req=1 and read_enable=0; a read wins a same-cycle collision.
- WR_OLD: fetch the old word.
- WR_COMMIT: RAM[addr] = wr_data; csum = csum + old - wr_data (mod 2^16); RAM[DEPTH-1] = csum. wr_ack pulses in this state.
- Write latency: ack 2 cycles after acceptance.
- Dropped writes (wr_ack and wr_err, RAM unchanged, still 2 cycles): wr_addr = DEPTH-1 (checksum is owned by the block), or wr_addr >= DEPTH.
- rst_i at any state, including mid-fill and WR_OLD/WR_COMMIT: the pending write is dropped without ack, FSM returns to INIT_WAIT, and the image is fully rebuilt.
- id_valid deasserting after init: no effect.

Optional Feature:
- Macro CONFIG_EEPROM_MAC_LOCK_EN.
- Defined: writes to words 0..2 are dropped with wr_ack+wr_err, so the MAC is immutable.
- Undefined: words 0..2 are writable like any other; mac_address still reflects the init-time MAC, not RAM.

Decomposition:
- Package config_eeprom_pkg:
  - FSM state enum
  - word address constants: MAC0=0x00, MAC1, MAC2, ICW1=0x0A … ICW2=0x0F, BAMSO=0x30
  - mac24 fold function
- Sub-module config_eeprom_defaults: combinational default-word generator (addr, mac24 → word), parametrised like the top.
- FSM, RAM, checksum and port logic live in config_eeprom.

Test Plan:
- Init, defaults: id = {9'h0, 24'h0, 24'h123456}, id_valid=1 → after 66 cycles (DEPTH=64) mac_valid=1, mac_address=48'hEC3F05123456. Read 0x00/0x01/0x02 → 16'h3FEC / 16'h1205 / 16'h5634.
- Checksum: read all 64 words → mod-2^16 sum = 16'hBABA. Read 0x40 → 16'hFFFF. Read 0x0E → 16'h8086.
- Write: write 0x03 ← 16'h1111 → wr_ack 2 cycles later, wr_err=0. Read 0x03 → 16'h1111. Word 0x3F decreased by 16'h1111. Total sum still 16'hBABA.
- Drop: write 0x3F ← 16'h0000 → wr_ack+wr_err, 0x3F unchanged. With CONFIG_EEPROM_MAC_LOCK_EN, write 0x01 ← 16'hFFFF → wr_err, read 0x01 = 16'h1205.
- Collision and hold-off:
  - read_enable and wr_req same IDLE cycle → read_valid next cycle; write acked 2 cycles after it is accepted in the following IDLE.
  - read_enable during INIT_FILL → no read_valid.
- Reset mid-operation: assert rst_i in WR_OLD → no wr_ack, ready=0, mac_valid=0. After refill, word 0x03 = 0 and sum = 16'hBABA.
